// File: rtl/pulse_event_arbiter_pkg.sv
// Shared types, defaults and helpers for the pulse event arbiter.
// Optional drop counters are compiled in with PULSE_EVENT_ARBITER_DROP_CNT_EN.
package pulse_event_arbiter_pkg;

  // Two-state offer FSM: nothing offered, or one event held for the consumer.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } arbState_t;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_CNT_W   = 8;

  // Widest counter the saturation helper handles; narrower counters are
  // zero-extended into it and truncated back by the caller.
  localparam int MAX_CNT_W = 32;

  // Increment a counter value, sticking at maxVal instead of wrapping.
  function automatic logic [MAX_CNT_W-1:0] satInc(
    input logic [MAX_CNT_W-1:0] value,
    input logic [MAX_CNT_W-1:0] maxVal
  );
    logic [MAX_CNT_W-1:0] result;
    if (value >= maxVal) begin
      result = maxVal;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pulse_event_arbiter_rr_priority_select.sv
// Round-robin selector: finds the first set request strictly after the
// last-granted index, wrapping around. Purely combinational.
module rr_priority_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [IDX_W-1:0]   lastGrant,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  int              cand;
  logic [IDX_W-1:0] candIdx;

  // Walk the requesters starting one past the last grant; first hit wins.
  always_comb begin
    found   = 1'b0;
    index   = '0;
    cand    = 0;
    candIdx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(lastGrant) + k) % NUM_REQ;
      candIdx = IDX_W'(cand);
      if (!found && reqVec[candIdx]) begin
        found = 1'b1;
        index = candIdx;
      end else begin
        index = index;
      end
    end
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Pulse event arbiter: latches single-cycle pulses as pending flags and offers
// them one at a time to a valid/ready consumer in round-robin order.
// Optional per-requester drop counters: define PULSE_EVENT_ARBITER_DROP_CNT_EN.
module pulse_event_arbiter
  import pulse_event_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                       ul1Clock,
  input  logic                       ul1Reset,
  input  logic [NUM_REQ-1:0]         ulvPulseIn,
  input  logic [NUM_REQ-1:0]         ulvEnable,
  output logic                       ul1EventValid,
  input  logic                       ul1EventReady,
  output logic [$clog2(NUM_REQ)-1:0] ulvEventId,
  output logic [NUM_REQ-1:0]         ulvPending,
  input  logic                       ul1DropClear,
  output logic [NUM_REQ*CNT_W-1:0]   ulvDropCnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arbState_t          stateR;
  logic               validR;
  logic [IDX_W-1:0]   idR;
  logic [IDX_W-1:0]   lastGrantR;
  logic [NUM_REQ-1:0] pendingR;

  logic [NUM_REQ-1:0] pendingNext;
  logic [NUM_REQ-1:0] pulseEnS;
  logic [NUM_REQ-1:0] offerMaskS;
  logic [NUM_REQ-1:0] acceptMaskS;
  logic [NUM_REQ-1:0] reqVecS;
  logic               selFoundS;
  logic [IDX_W-1:0]   selIndexS;

  // Decode which requester is offered/accepted and the next pending flags.
  always_comb begin
    pulseEnS    = ulvPulseIn & ulvEnable;
    offerMaskS  = '0;
    acceptMaskS = '0;
    pendingNext = pendingR;
    for (int i = 0; i < NUM_REQ; i++) begin
      offerMaskS[i]  = (stateR == S_OFFER) && (idR == IDX_W'(i));
      acceptMaskS[i] = offerMaskS[i] && ul1EventReady;
      if (pulseEnS[i]) begin
        // A fresh pulse always wins, even in the cycle its old event is accepted.
        pendingNext[i] = 1'b1;
      end else if (acceptMaskS[i]) begin
        pendingNext[i] = 1'b0;
      end else if (!ulvEnable[i] && !offerMaskS[i]) begin
        // Disabled requesters are flushed unless their event is on the bus.
        pendingNext[i] = 1'b0;
      end else begin
        pendingNext[i] = pendingR[i];
      end
    end
    // Only enabled requesters compete, so a flag being flushed is never offered.
    reqVecS = pendingR & ulvEnable;
  end

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rrSelect (
    .reqVec    (reqVecS),
    .lastGrant (lastGrantR),
    .found     (selFoundS),
    .index     (selIndexS)
  );

  // Pending flag register.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      pendingR <= '0;
    end else begin
      pendingR <= pendingNext;
    end
  end

  // Offer FSM: pick a winner when idle, hold it stable until accepted.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset) begin
      stateR     <= S_IDLE;
      validR     <= 1'b0;
      idR        <= '0;
      lastGrantR <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (stateR)
        S_IDLE: begin
          if (selFoundS) begin
            idR    <= selIndexS;
            validR <= 1'b1;
            stateR <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (ul1EventReady) begin
            lastGrantR <= idR;
            validR     <= 1'b0;
            stateR     <= S_IDLE;
          end
        end
        default: begin
          validR <= 1'b0;
          stateR <= S_IDLE;
        end
      endcase
    end
  end

  assign ul1EventValid = validR;
  assign ulvEventId    = idR;
  assign ulvPending    = pendingR;

`ifdef PULSE_EVENT_ARBITER_DROP_CNT_EN
  logic [NUM_REQ-1:0]       dropS;
  logic [CNT_W-1:0]         dropCntR [NUM_REQ];
  logic [CNT_W-1:0]         dropIncS [NUM_REQ];
  logic [NUM_REQ*CNT_W-1:0] dropCntPackedS;

  // A drop is a pulse landing on a flag that is already set and not being accepted.
  always_comb begin
    dropS          = pulseEnS & pendingR & ~acceptMaskS;
    dropCntPackedS = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dropIncS[i] = CNT_W'(satInc(MAX_CNT_W'(dropCntR[i]), MAX_CNT_W'({CNT_W{1'b1}})));
      dropCntPackedS[i*CNT_W +: CNT_W] = dropCntR[i];
    end
  end

  // Saturating drop counters; a clear discards any drop in the same cycle.
  always_ff @(posedge ul1Clock) begin
    if (ul1Reset || ul1DropClear) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        dropCntR[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (dropS[i]) begin
          dropCntR[i] <= dropIncS[i];
        end
      end
    end
  end

  assign ulvDropCnt = dropCntPackedS;
`else
  logic unusedDropClear;

  assign unusedDropClear = ul1DropClear;
  assign ulvDropCnt      = '0;
`endif

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed self-checking bench for pulse_event_arbiter (NUM_REQ=4, CNT_W=8).
// Drop-counter expectations follow PULSE_EVENT_ARBITER_DROP_CNT_EN.
module tb_pulse_event_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;
`ifdef PULSE_EVENT_ARBITER_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic                     ul1Clock = 1'b0;
  logic                     ul1Reset;
  logic [NUM_REQ-1:0]       ulvPulseIn;
  logic [NUM_REQ-1:0]       ulvEnable;
  logic                     ul1EventValid;
  logic                     ul1EventReady;
  logic [1:0]               ulvEventId;
  logic [NUM_REQ-1:0]       ulvPending;
  logic                     ul1DropClear;
  logic [NUM_REQ*CNT_W-1:0] ulvDropCnt;

  int checkCnt = 0;
  int errCnt   = 0;

  pulse_event_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W)
  ) dut (
    .ul1Clock      (ul1Clock),
    .ul1Reset      (ul1Reset),
    .ulvPulseIn    (ulvPulseIn),
    .ulvEnable     (ulvEnable),
    .ul1EventValid (ul1EventValid),
    .ul1EventReady (ul1EventReady),
    .ulvEventId    (ulvEventId),
    .ulvPending    (ulvPending),
    .ul1DropClear  (ul1DropClear),
    .ulvDropCnt    (ulvDropCnt)
  );

  always #5 ul1Clock = ~ul1Clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ul1Clock);
    #1;
  endtask

  task automatic doReset();
    ul1Reset      = 1'b1;
    ulvPulseIn    = '0;
    ulvEnable     = '1;
    ul1EventReady = 1'b0;
    ul1DropClear  = 1'b0;
    tick();
    tick();
    ul1Reset = 1'b0;
  endtask

  function automatic logic [31:0] dropOf(input int idx);
    return 32'(ulvDropCnt[idx*CNT_W +: CNT_W]);
  endfunction

  initial begin
    int expIds[3];
    expIds[0] = 0;
    expIds[1] = 1;
    expIds[2] = 3;

    // Reset state
    doReset();
    checkVal("rst_valid", 32'(ul1EventValid), 32'd0);
    checkVal("rst_id", 32'(ulvEventId), 32'd0);
    checkVal("rst_pending", 32'(ulvPending), 32'd0);
    checkVal("rst_drop", ulvDropCnt, 32'd0);

    // Single pulse on requester 2: valid two cycles later, gone one after.
    ulvPulseIn    = 4'b0100;
    ul1EventReady = 1'b1;
    tick();
    ulvPulseIn = 4'b0000;
    checkVal("t1_pend", 32'(ulvPending), 32'h4);
    checkVal("t1_valid_early", 32'(ul1EventValid), 32'd0);
    tick();
    checkVal("t1_valid", 32'(ul1EventValid), 32'd1);
    checkVal("t1_id", 32'(ulvEventId), 32'd2);
    tick();
    checkVal("t1_valid_off", 32'(ul1EventValid), 32'd0);
    checkVal("t1_pend_clr", 32'(ulvPending), 32'd0);

    // Simultaneous pulses on 0,1,3 with ready high: 0,1,3 with idle gaps.
    doReset();
    ul1EventReady = 1'b1;
    ulvPulseIn    = 4'b1011;
    tick();
    ulvPulseIn = 4'b0000;
    checkVal("t2_pend", 32'(ulvPending), 32'hB);
    for (int n = 0; n < 3; n++) begin
      tick();
      checkVal("t2_valid", 32'(ul1EventValid), 32'd1);
      checkVal("t2_id", 32'(ulvEventId), 32'(expIds[n]));
      tick();
      checkVal("t2_gap", 32'(ul1EventValid), 32'd0);
    end
    checkVal("t2_pend_end", 32'(ulvPending), 32'd0);

    // Held offer of id 1 while 0 and 2 arrive; then 2 before 0.
    doReset();
    ulvPulseIn = 4'b0010;
    tick();
    ulvPulseIn = 4'b0000;
    tick();
    checkVal("t3_id_start", 32'(ulvEventId), 32'd1);
    ulvPulseIn = 4'b0101;
    for (int n = 0; n < 5; n++) begin
      tick();
      ulvPulseIn = 4'b0000;
      checkVal("t3_hold_valid", 32'(ul1EventValid), 32'd1);
      checkVal("t3_hold_id", 32'(ulvEventId), 32'd1);
    end
    checkVal("t3_pend", 32'(ulvPending), 32'h7);
    ul1EventReady = 1'b1;
    tick();
    checkVal("t3_acc_valid", 32'(ul1EventValid), 32'd0);
    tick();
    checkVal("t3_next_id", 32'(ulvEventId), 32'd2);
    checkVal("t3_next_valid", 32'(ul1EventValid), 32'd1);
    tick();
    tick();
    checkVal("t3_last_id", 32'(ulvEventId), 32'd0);
    checkVal("t3_last_valid", 32'(ul1EventValid), 32'd1);
    tick();
    checkVal("t3_pend_end", 32'(ulvPending), 32'd0);

    // Pulse on requester 1 in its own accept cycle: re-offered, no drop.
    doReset();
    ulvPulseIn = 4'b0010;
    tick();
    ulvPulseIn = 4'b0000;
    tick();
    checkVal("t4_id", 32'(ulvEventId), 32'd1);
    ulvPulseIn    = 4'b0010;
    ul1EventReady = 1'b1;
    tick();
    ulvPulseIn = 4'b0000;
    checkVal("t4_pend_kept", 32'(ulvPending), 32'h2);
    checkVal("t4_valid_gap", 32'(ul1EventValid), 32'd0);
    checkVal("t4_drop1", dropOf(1), 32'd0);
    tick();
    checkVal("t4_reoffer_valid", 32'(ul1EventValid), 32'd1);
    checkVal("t4_reoffer_id", 32'(ulvEventId), 32'd1);
    tick();
    checkVal("t4_pend_end", 32'(ulvPending), 32'd0);

    // 300 back-to-back pulses on requester 0 while the consumer stalls.
    doReset();
    ulvPulseIn = 4'b0001;
    for (int n = 0; n < 11; n++) tick();
    checkVal("t5_drop_10", dropOf(0), 32'(10 * DROP_EN));
    for (int n = 11; n < 256; n++) tick();
    checkVal("t5_drop_255", dropOf(0), 32'(255 * DROP_EN));
    for (int n = 256; n < 300; n++) tick();
    checkVal("t5_drop_sat", dropOf(0), 32'(255 * DROP_EN));
    checkVal("t5_drop1_idle", dropOf(1), 32'd0);
    checkVal("t5_valid", 32'(ul1EventValid), 32'd1);
    checkVal("t5_id", 32'(ulvEventId), 32'd0);
    ul1DropClear = 1'b1;
    tick();
    checkVal("t5_clear_wins", dropOf(0), 32'd0);
    ul1DropClear = 1'b0;
    tick();
    ulvPulseIn = 4'b0000;
    checkVal("t5_after_clear", dropOf(0), 32'(DROP_EN));

    // Disable flushes a non-offered pending flag; disabled pulses ignored.
    doReset();
    ulvPulseIn = 4'b0010;
    tick();
    ulvPulseIn = 4'b0000;
    tick();
    ulvPulseIn = 4'b1000;
    tick();
    ulvPulseIn = 4'b0000;
    checkVal("t6_pend", 32'(ulvPending), 32'hA);
    ulvEnable  = 4'b0011;
    ulvPulseIn = 4'b0100;
    tick();
    ulvPulseIn = 4'b0000;
    checkVal("t6_flushed", 32'(ulvPending), 32'h2);
    checkVal("t6_offer_kept", 32'(ul1EventValid), 32'd1);
    ulvEnable     = 4'b1111;
    ul1EventReady = 1'b1;
    tick();
    tick();
    checkVal("t6_no_offer", 32'(ul1EventValid), 32'd0);
    checkVal("t6_pend_end", 32'(ulvPending), 32'd0);

    // Reset in the middle of an offer; pulses during reset ignored.
    ul1EventReady = 1'b0;
    ulvPulseIn    = 4'b0010;
    tick();
    ulvPulseIn = 4'b0000;
    tick();
    checkVal("t7_offer", 32'(ul1EventValid), 32'd1);
    ul1Reset   = 1'b1;
    ulvPulseIn = 4'b0100;
    tick();
    checkVal("t7_rst_valid", 32'(ul1EventValid), 32'd0);
    checkVal("t7_rst_id", 32'(ulvEventId), 32'd0);
    checkVal("t7_rst_pend", 32'(ulvPending), 32'd0);
    ul1Reset   = 1'b0;
    ulvPulseIn = 4'b0000;
    tick();
    checkVal("t7_pulse_ignored", 32'(ulvPending), 32'd0);
    // After reset the search restarts at 0 even though 1 was last granted.
    ulvPulseIn = 4'b1001;
    tick();
    ulvPulseIn = 4'b0000;
    tick();
    checkVal("t7_first_grant", 32'(ulvEventId), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
